// File: rtl/simple_nios_lab_pkg.sv
// Shared definitions for the on-chip RAM tester: FSM state encoding,
// pattern-mode encodings and the default Galois LFSR polynomial.
package simple_nios_lab_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_FINISH
  } state_t;

  typedef enum logic [1:0] {
    MODE_ADDR  = 2'd0,
    MODE_NADDR = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_t;

  localparam logic [31:0] LFSR_POLY_DEFAULT = 32'h8020_0003;

endpackage

// File: rtl/simple_nios_lab_patgen.sv
// Pattern generator for the RAM tester.
//   clk, reset_n : clock, async active-low reset
//   mode         : pattern mode, captured on load (reserved mode acts as address mode)
//   seed         : load value; LFSR seed in LFSR mode, zero-extended start address otherwise
//   load         : restart the sequence from seed (wins over advance)
//   advance      : step to the next word
//   pattern      : current pattern word
module simple_nios_lab_patgen
  import simple_nios_lab_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 11,
  parameter logic [DATA_W-1:0] LFSR_POLY = LFSR_POLY_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic              load,
  input  logic              advance,
  output logic [DATA_W-1:0] pattern
);

  mode_t             mode_q;
  logic [DATA_W-1:0] st;
  logic [DATA_W-1:0] lfsr_nx;
  logic [DATA_W-1:0] addr_word;

  always_comb lfsr_nx = (st >> 1) ^ (st[0] ? LFSR_POLY : '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= MODE_ADDR;
      st     <= '0;
    end else if (load) begin
      mode_q <= mode_t'(mode);
      // An all-zero LFSR state would lock up, so a zero seed becomes 1.
      if (mode_t'(mode) == MODE_LFSR && seed == '0) st <= DATA_W'(1);
      else                                          st <= seed;
    end else if (advance) begin
      if (mode_q == MODE_LFSR) st <= lfsr_nx;
      else                     st <= st + DATA_W'(1);
    end
  end

  // Address modes only look at the low ADDR_W bits, so the counter wraps with the bus address.
  always_comb begin
    addr_word              = '0;
    addr_word[ADDR_W-1:0]  = st[ADDR_W-1:0];
    pattern                = addr_word;
    case (mode_q)
      MODE_LFSR:  pattern = st;
      MODE_NADDR: pattern = ~addr_word;
      default:    pattern = addr_word;
    endcase
  end

endmodule

// File: rtl/simple_nios_lab_onchip_tester.sv
// Avalon-MM BIST master for the single-port on-chip RAM (s1 port).
// On an accepted start it writes a generated pattern over a word range,
// reads it back one word per cycle, compares and reports the result.
//   start/mode/seed/base_addr/word_count : test request, sampled on an accepted start
//   busy/done/pass/err_count/first_err_addr : status; pass valid from done to next start
//   m_* : Avalon-MM master towards the RAM (no waitrequest, fixed read latency)
module simple_nios_lab_onchip_tester
  import simple_nios_lab_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 11,
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       READ_LATENCY = 1,
  parameter int unsigned       ERR_W        = 12,
  parameter logic [DATA_W-1:0] LFSR_POLY    = LFSR_POLY_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [DATA_W-1:0]     seed,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic [ADDR_W-1:0]     m_address,
  output logic                  m_chipselect,
  output logic                  m_write,
  output logic [DATA_W/8-1:0]   m_byteenable,
  output logic [DATA_W-1:0]     m_writedata,
  output logic                  m_clken,
  input  logic [DATA_W-1:0]     m_readdata
);

  state_t              state, state_nx;
  logic [ADDR_W:0]     idx;
  logic [ADDR_W:0]     cnt_q;
  logic [ADDR_W-1:0]   base_q;
  logic [1:0]          mode_q;
  logic [DATA_W-1:0]   seed_q;
  logic                accept;
  logic                last_word;
  logic                drain_last;
  logic [ADDR_W-1:0]   bus_addr;
  logic                pg_load;
  logic                pg_advance;
  logic [1:0]          ld_mode;
  logic [DATA_W-1:0]   ld_val;
  logic [DATA_W-1:0]   pattern;
  logic [ERR_W-1:0]    err_q;
  logic [ADDR_W-1:0]   first_q;
  logic                pass_q;
  logic                mismatch;

  logic [DATA_W-1:0]       exp_pipe  [READ_LATENCY];
  logic [ADDR_W-1:0]       addr_pipe [READ_LATENCY];
  logic [READ_LATENCY-1:0] vld_pipe;

  assign accept     = (state == ST_IDLE) && start;
  assign last_word  = (idx == cnt_q - (ADDR_W+1)'(1));
  assign drain_last = (idx == (ADDR_W+1)'(READ_LATENCY - 1));
  assign bus_addr   = base_q + idx[ADDR_W-1:0];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start) state_nx = (word_count == '0) ? ST_FINISH : ST_WRITE;
      ST_WRITE:  if (last_word) state_nx = ST_READ;
      ST_READ:   if (last_word) state_nx = ST_DRAIN;
      ST_DRAIN:  if (drain_last) state_nx = ST_FINISH;
      ST_FINISH: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy         = (state != ST_IDLE);
    done         = (state == ST_FINISH);
    m_chipselect = (state == ST_WRITE) || (state == ST_READ);
    m_write      = (state == ST_WRITE);
    m_byteenable = m_chipselect ? '1 : '0;
    m_address    = m_chipselect ? bus_addr : '0;
    m_writedata  = (state == ST_WRITE) ? pattern : '0;
  end

  assign m_clken = 1'b1;

  // Per-phase word counter and request capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx    <= '0;
      cnt_q  <= '0;
      base_q <= '0;
      mode_q <= '0;
      seed_q <= '0;
    end else begin
      if (state != state_nx)   idx <= '0;
      else if (state != ST_IDLE) idx <= idx + (ADDR_W+1)'(1);
      if (accept) begin
        cnt_q  <= word_count;
        base_q <= base_addr;
        mode_q <= mode;
        seed_q <= seed;
      end
    end
  end

  // The generator is loaded at start from the live inputs and reloaded on the
  // last write from the captured copies, so the read pass replays the write pass.
  always_comb begin
    ld_mode = accept ? mode : mode_q;
    ld_val  = '0;
    if (mode_t'(ld_mode) == MODE_LFSR) ld_val = accept ? seed : seed_q;
    else                               ld_val[ADDR_W-1:0] = accept ? base_addr : base_q;
  end

  assign pg_load    = accept || ((state == ST_WRITE) && last_word);
  assign pg_advance = (state == ST_WRITE) || (state == ST_READ);

  simple_nios_lab_patgen #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .LFSR_POLY (LFSR_POLY)
  ) u_patgen (
    .clk     (clk),
    .reset_n (reset_n),
    .mode    (ld_mode),
    .seed    (ld_val),
    .load    (pg_load),
    .advance (pg_advance),
    .pattern (pattern)
  );

  // Expected-data pipeline aligned with the slave read latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= (state == ST_READ);
      for (int unsigned i = 1; i < READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    exp_pipe[0]  <= pattern;
    addr_pipe[0] <= bus_addr;
    for (int unsigned i = 1; i < READ_LATENCY; i++) begin
      exp_pipe[i]  <= exp_pipe[i-1];
      addr_pipe[i] <= addr_pipe[i-1];
    end
  end

  assign mismatch = vld_pipe[READ_LATENCY-1] && (m_readdata != exp_pipe[READ_LATENCY-1]);

  // Error accounting and pass flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q   <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
    end else if (accept) begin
      err_q   <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      if (mismatch) begin
        if (err_q != '1) err_q <= err_q + ERR_W'(1);
        if (err_q == '0) first_q <= addr_pipe[READ_LATENCY-1];
      end
      if (state == ST_FINISH) pass_q <= (err_q == '0);
    end
  end

  // The last compare retires at the end of DRAIN, so FINISH already sees the final count.
  assign pass           = (state == ST_FINISH) ? (err_q == '0) : pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;

endmodule

// File: tb/tb_simple_nios_lab_onchip_tester.sv
module tb_simple_nios_lab_onchip_tester;

  localparam int          RL   = 1;
  localparam logic [31:0] POLY = 32'h8020_0003;

  typedef struct {
    logic        pass;
    logic [11:0] err;
    logic [10:0] first;
    int          done_cyc;
  } res_t;

  typedef struct {
    logic        wr;
    logic [10:0] addr;
    logic [31:0] data;
  } bus_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start, start2;
  logic [1:0]  mode;
  logic [31:0] seed;
  logic [10:0] base_addr;
  logic [11:0] word_count;

  logic        busy, done, pass, m_chipselect, m_write, m_clken;
  logic [11:0] err_count;
  logic [10:0] first_err_addr, m_address;
  logic [3:0]  m_byteenable;
  logic [31:0] m_writedata, m_readdata;

  logic        d2_busy, d2_done, d2_pass, d2_cs, d2_write, d2_clken;
  logic [3:0]  d2_err;
  logic [10:0] d2_first, d2_address;
  logic [3:0]  d2_be;
  logic [31:0] d2_wdata, d2_rdata;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   wr_seen = 0;
  bit   bus_chk = 1'b1;
  res_t q1[$];
  res_t q2[$];
  bus_t bq[$];

  simple_nios_lab_onchip_tester #(
    .ADDR_W(11), .DATA_W(32), .READ_LATENCY(RL), .ERR_W(12)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .seed(seed),
    .base_addr(base_addr), .word_count(word_count), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write(m_write),
    .m_byteenable(m_byteenable), .m_writedata(m_writedata), .m_clken(m_clken),
    .m_readdata(m_readdata)
  );

  simple_nios_lab_onchip_tester #(
    .ADDR_W(11), .DATA_W(32), .READ_LATENCY(RL), .ERR_W(4)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .mode(mode), .seed(seed),
    .base_addr(base_addr), .word_count(word_count), .busy(d2_busy), .done(d2_done),
    .pass(d2_pass), .err_count(d2_err), .first_err_addr(d2_first),
    .m_address(d2_address), .m_chipselect(d2_cs), .m_write(d2_write),
    .m_byteenable(d2_be), .m_writedata(d2_wdata), .m_clken(d2_clken),
    .m_readdata(d2_rdata)
  );

  // RAM models: address registered, readdata valid one cycle later.
  // flip[] is the per-address fault hook (XOR mask on read); mem2 is faulty everywhere.
  logic [31:0] mem  [2048];
  logic [31:0] flip [2048];
  logic [31:0] mem2 [2048];
  logic [31:0] rd_q  = '0;
  logic [31:0] rd2_q = '0;

  always @(posedge clk) begin
    if (m_chipselect && m_write)  mem[m_address] <= m_writedata;
    if (m_chipselect && !m_write) rd_q <= mem[m_address] ^ flip[m_address];
    if (d2_cs && d2_write)        mem2[d2_address] <= d2_wdata;
    if (d2_cs && !d2_write)       rd2_q <= mem2[d2_address] ^ 32'h1;
  end
  assign m_readdata = rd_q;
  assign d2_rdata   = rd2_q;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] galois(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 32'h0);
  endfunction

  function automatic logic [31:0] exp_word(input logic [1:0] md, input logic [10:0] a,
                                           input logic [31:0] s);
    if (md == 2'd2) return s;
    if (md == 2'd1) return ~{21'b0, a};
    return {21'b0, a};
  endfunction

  // Result monitor
  always @(negedge clk) begin
    res_t r;
    if (done) begin
      if (q1.size() == 0) chk("unexpected_done", 1'b1, 1'b0);
      else begin
        r = q1.pop_front();
        chk("pass", pass, r.pass);
        chk("err_count", err_count, r.err);
        chk("first_err_addr", first_err_addr, r.first);
        chk("done_cycle", cyc, r.done_cyc);
      end
    end
    if (d2_done) begin
      if (q2.size() == 0) chk("unexpected_done2", 1'b1, 1'b0);
      else begin
        r = q2.pop_front();
        chk("pass2", d2_pass, r.pass);
        chk("err_count2", d2_err, r.err);
        chk("first_err_addr2", d2_first, r.first);
        chk("done_cycle2", cyc, r.done_cyc);
      end
    end
  end

  // Bus monitor
  always @(negedge clk) begin
    bus_t t;
    if (m_chipselect && m_write) wr_seen++;
    if (m_chipselect && bus_chk) begin
      if (bq.size() == 0) chk("unexpected_chipselect", m_address, 11'h7FF);
      else begin
        t = bq.pop_front();
        chk("bus_write", m_write, t.wr);
        chk("bus_addr", m_address, t.addr);
        chk("bus_be", m_byteenable, 4'hF);
        if (t.wr) chk("bus_wdata", m_writedata, t.data);
      end
    end
  end

  task automatic go(input bit second, input logic [1:0] md, input logic [31:0] sd,
                    input logic [10:0] b, input int n, input bit exp_done,
                    input logic ep, input int ee, input int ef, input bit bus);
    res_t        r;
    bus_t        t;
    logic [31:0] s;
    @(posedge clk); #1;
    mode = md; seed = sd; base_addr = b; word_count = 12'(n);
    r.pass = ep; r.err = 12'(ee); r.first = 11'(ef);
    // Start cycle and done cycle together span 2*n+RL+2 cycles; n=0 finishes next cycle.
    r.done_cyc = cyc + ((n == 0) ? 1 : 2*n + RL + 1);
    if (exp_done) begin
      if (second) q2.push_back(r); else q1.push_back(r);
    end
    if (second) start2 = 1'b1; else start = 1'b1;
    if (bus) begin
      s = (sd == 32'h0) ? 32'h1 : sd;
      for (int i = 0; i < n; i++) begin
        t.wr = 1'b1; t.addr = b + 11'(i); t.data = exp_word(md, t.addr, s);
        bq.push_back(t);
        s = galois(s);
      end
      for (int i = 0; i < n; i++) begin
        t.wr = 1'b0; t.addr = b + 11'(i); t.data = 32'h0;
        bq.push_back(t);
      end
    end
    @(posedge clk); #1;
    start = 1'b0; start2 = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while ((q1.size() != 0 || q2.size() != 0) && i < budget) begin
      @(posedge clk); i++;
    end
    if (q1.size() != 0 || q2.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: still waiting after %0d cycles", budget);
      q1.delete(); q2.delete();
    end
    chk("bus_queue_drained", bq.size(), 0);
    bq.delete();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_first"}, first_err_addr, 0);
    chk({tag, "_addr"}, m_address, 0);
    chk({tag, "_cs"}, m_chipselect, 0);
    chk({tag, "_write"}, m_write, 0);
    chk({tag, "_be"}, m_byteenable, 0);
    chk({tag, "_wdata"}, m_writedata, 0);
    chk({tag, "_clken"}, m_clken, 1);
  endtask

  initial begin
    int w0;
    int cs_hi;
    bit found;
    for (int i = 0; i < 2048; i++) begin
      mem[i] = '0; mem2[i] = '0; flip[i] = '0;
    end
    reset_n = 1'b0; start = 1'b0; start2 = 1'b0;
    mode = '0; seed = '0; base_addr = '0; word_count = '0;
    repeat (3) @(posedge clk);
    #1 chk_idle("in_reset");
    reset_n = 1'b1;
    @(negedge clk);
    chk_idle("after_reset");

    // 1: full-array address pattern
    go(0, 2'd0, 32'h0, 11'd0, 2048, 1, 1'b1, 0, 0, 1);
    wait_done(4200);
    chk("ram5_after_full", mem[5], 32'h5);

    // 2: LFSR pattern with zero seed
    go(0, 2'd2, 32'h0, 11'd100, 16, 1, 1'b1, 0, 0, 1);
    wait_done(100);
    chk("lfsr_word0", mem[100], 32'h0000_0001);
    chk("lfsr_word1", mem[101], 32'h8020_0003);
    chk("lfsr_word2", mem[102], 32'hC030_0002);

    // 3: inverted address across the wrap, bit 0 flipped on reads of address 3
    chk("pass_held_until_start", pass, 1);
    flip[3] = 32'h1;
    go(0, 2'd1, 32'h0, 11'd2040, 16, 1, 1'b0, 1, 3, 1);
    chk("pass_cleared_at_start", pass, 0);
    wait_done(100);
    flip[3] = 32'h0;

    // 4: empty range; a start during FINISH must be ignored
    go(0, 2'd0, 32'h0, 11'd9, 0, 1, 1'b1, 0, 0, 1);
    word_count = 12'd5;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(20);
    repeat (20) @(posedge clk);
    chk("idle_after_empty", busy, 0);

    // 6: every read faulty, 4-bit counter saturates
    go(1, 2'd0, 32'h0, 11'd500, 32, 1, 1'b0, 15, 500, 0);
    wait_done(200);

    // 5: second start mid-WRITE ignored, then reset during READ
    bus_chk = 1'b0;
    w0 = wr_seen;
    go(0, 2'd0, 32'h0, 11'd0, 64, 0, 1'b0, 0, 0, 0);
    repeat (10) @(posedge clk);
    #1 mode = 2'd1; base_addr = 11'd5; word_count = 12'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (m_chipselect && !m_write) found = 1'b1;
    end
    chk("reached_read", found, 1);
    chk("writes_before_read", wr_seen - w0, 64);
    chk("first_read_addr", m_address, 0);
    #2 reset_n = 1'b0;
    #1 chk_idle("abort");
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    cs_hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_chipselect) cs_hi++;
    end
    chk("cs_after_abort", cs_hi, 0);
    chk("no_pending_results", q1.size() + q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
